// File: rtl/coin_pkg.sv
// Shared definitions for the coin collision engine and the coin renderer.
package coin_pkg;

    localparam int COORD_W          = 10;
    localparam int COIN_W_DEFAULT   = 16;
    localparam int COIN_H_DEFAULT   = 28;
    localparam int PLAYER_W_DEFAULT = 16;
    localparam int PLAYER_H_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } collect_state_t;

endpackage

// File: rtl/coin_collector_if.sv
// Bus between the player/coin bank and the coin collector.
interface coin_collector_if #(
    parameter int N_COINS = 8
);
    logic [9:0]            player_x;
    logic [9:0]            player_y;
    logic [10*N_COINS-1:0] coin_x_all;
    logic [10*N_COINS-1:0] coin_y_all;
    logic [N_COINS-1:0]    coin_alive;
    logic [7:0]            coin_count;
    logic                  collect_pulse;
    logic                  all_collected;
    logic                  busy;

    modport master (
        output player_x, player_y, coin_x_all, coin_y_all,
        input  coin_alive, coin_count, collect_pulse, all_collected, busy
    );

    modport slave (
        input  player_x, player_y, coin_x_all, coin_y_all,
        output coin_alive, coin_count, collect_pulse, all_collected, busy
    );
endinterface

// File: rtl/coin_hit_test.sv
// Combinational player/coin rectangle overlap; edges that only touch are not a hit.
module coin_hit_test #(
    parameter int COIN_W   = 16,
    parameter int COIN_H   = 28,
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 32
) (
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic       hit
);
    // 11-bit sums keep right/bottom edges from wrapping near the world limit
    logic [10:0] px_e, py_e, cx_e, cy_e;
    logic [10:0] p_right, p_bottom, c_right, c_bottom;

    assign px_e     = {1'b0, px};
    assign py_e     = {1'b0, py};
    assign cx_e     = {1'b0, cx};
    assign cy_e     = {1'b0, cy};
    assign p_right  = px_e + 11'(PLAYER_W);
    assign p_bottom = py_e + 11'(PLAYER_H);
    assign c_right  = cx_e + 11'(COIN_W);
    assign c_bottom = cy_e + 11'(COIN_H);

    assign hit = (cx_e < p_right) && (px_e < c_right) &&
                 (cy_e < p_bottom) && (py_e < c_bottom);
endmodule

// File: rtl/coin_collector.sv
// Frame-triggered coin collision scanner: one coin per Clk, clears touched coins.
module coin_collector
    import coin_pkg::*;
#(
    parameter int N_COINS  = 8,
    parameter int COIN_W   = COIN_W_DEFAULT,
    parameter int COIN_H   = COIN_H_DEFAULT,
    parameter int PLAYER_W = PLAYER_W_DEFAULT,
    parameter int PLAYER_H = PLAYER_H_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             enable,
    coin_collector_if.slave  bus
);
    collect_state_t     state, state_nxt;
    logic               fd, rise;
    logic [9:0]         px, py;
    logic [7:0]         idx;
    logic               hit_frame;
    logic [N_COINS-1:0] alive;
    logic [7:0]         count;
    logic               pulse;
    logic               all_done;

    logic [9:0]         cx, cy;
    logic               alive_sel;
    logic [N_COINS-1:0] sel_mask;
    logic               hit;
    logic               last;

    always_comb begin
        cx        = '0;
        cy        = '0;
        alive_sel = 1'b0;
        sel_mask  = '0;
        for (int k = 0; k < N_COINS; k++) begin
            if (idx == 8'(k)) begin
                cx          = bus.coin_x_all[10*k +: 10];
                cy          = bus.coin_y_all[10*k +: 10];
                alive_sel   = alive[k];
                sel_mask[k] = 1'b1;
            end
        end
    end

    assign last = (idx == 8'(N_COINS - 1));

    coin_hit_test #(
        .COIN_W   (COIN_W),
        .COIN_H   (COIN_H),
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H)
    ) u_hit (
        .px  (px),
        .py  (py),
        .cx  (cx),
        .cy  (cy),
        .hit (hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise && enable) state_nxt = SCAN;
            SCAN:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fd        <= 1'b0;
            rise      <= 1'b0;
            px        <= '0;
            py        <= '0;
            idx       <= '0;
            hit_frame <= 1'b0;
            alive     <= '1;
            count     <= '0;
            pulse     <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            fd    <= frame_clk;
            rise  <= frame_clk & ~fd;
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise && enable) begin
                        px        <= bus.player_x;
                        py        <= bus.player_y;
                        idx       <= '0;
                        hit_frame <= 1'b0;
                    end
                end
                SCAN: begin
                    // collected coins park at (0,0), so only live coins may score
                    if (alive_sel && hit) begin
                        alive     <= alive & ~sel_mask;
                        count     <= count + 8'd1;
                        hit_frame <= 1'b1;
                    end
                    if (!last) idx <= idx + 8'd1;
                end
                DONE: begin
                    pulse    <= hit_frame;
                    all_done <= (alive == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.coin_alive    = alive;
    assign bus.coin_count    = count;
    assign bus.collect_pulse = pulse;
    assign bus.all_collected = all_done;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_coin_collector.sv
// Randomised and directed frames against a rectangle-intersection model, scoreboard-checked.
module tb_coin_collector;
    localparam int N  = 8;
    localparam int CW = 16;
    localparam int CH = 28;
    localparam int PW = 16;
    localparam int PH = 32;

    typedef struct {
        logic [7:0] alive;
        int         count;
        bit         pulse;
        bit         all;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;
    logic enable;

    coin_collector_if #(.N_COINS(N)) bus ();

    coin_collector #(.N_COINS(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .enable    (enable),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    bit   m_alive[N];
    int   m_count;
    int   bx[N];
    int   by[N];
    int   exp_pulses = 0;
    int   pulses_seen = 0;

    int   cyc = 0;
    int   start_cyc = 0;
    bit   prev_busy = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // two half-open rectangles overlap when both axis intervals intersect
    function automatic bit overlap(input int x, input int y, input int cx, input int cy);
        return (imax(x, cx) < imin(x + PW, cx + CW)) &&
               (imax(y, cy) < imin(y + PH, cy + CH));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_alive[k] = 1'b1;
        m_count = 0;
    endtask

    task automatic base_layout();
        for (int k = 0; k < N; k++) begin
            bx[k] = 100 + 50 * k;
            by[k] = 300;
        end
    endtask

    task automatic drive_coins();
        for (int k = 0; k < N; k++) begin
            bus.coin_x_all[10*k +: 10] = m_alive[k] ? 10'(bx[k]) : 10'd0;
            bus.coin_y_all[10*k +: 10] = m_alive[k] ? 10'(by[k]) : 10'd0;
        end
    endtask

    task automatic model_scan(input int x, input int y, output exp_t e);
        bit hit_any = 1'b0;
        bit none_left = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (m_alive[k] && overlap(x, y, bx[k], by[k])) begin
                m_alive[k] = 1'b0;
                m_count++;
                hit_any = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            e.alive[k] = m_alive[k];
            if (m_alive[k]) none_left = 1'b0;
        end
        e.count = m_count;
        e.pulse = hit_any;
        e.all   = none_left;
        if (hit_any) exp_pulses++;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        cyc++;
        if (Reset) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.collect_pulse) pulses_seen++;
            if (bus.busy && !prev_busy) start_cyc = cyc;
            if (!bus.busy && prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_scan", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("coin_alive",    longint'(bus.coin_alive),    longint'(e.alive));
                    chk("coin_count",    longint'(bus.coin_count),    longint'(e.count));
                    chk("collect_pulse", longint'(bus.collect_pulse), longint'(e.pulse));
                    chk("all_collected", longint'(bus.all_collected), longint'(e.all));
                    chk("scan_latency",  longint'(cyc - start_cyc),   longint'(N + 1));
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic do_frame(input int xi, input int yi, input bit en,
                            input bit scramble, input bit drop_en, input int watch);
        exp_t e;
        int   rel = -1;
        int   busy_seen = 0;
        int   x = imin(imax(xi, 0), 1023);
        int   y = imin(imax(yi, 0), 1023);
        drive_coins();
        bus.player_x = 10'(x);
        bus.player_y = 10'(y);
        enable = en;
        if (en) begin
            model_scan(x, y, e);
            exp_q.push_back(e);
        end
        frame_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i == 2) frame_clk = 1'b0;
            if (bus.busy) busy_seen++;
            if (bus.busy && rel < 0) rel = 0;
            else if (rel >= 0) rel++;
            if (watch >= 0 && rel == 3)
                chk("alive_before_eval", longint'(bus.coin_alive[watch]), 1);
            if (watch >= 0 && rel == 4)
                chk("alive_after_eval", longint'(bus.coin_alive[watch]), 0);
            if (bus.busy && scramble) begin
                bus.player_x = 10'($urandom);
                bus.player_y = 10'($urandom);
            end
            if (bus.busy && drop_en) enable = 1'b0;
        end
        if (!en) chk("busy_while_disabled", longint'(busy_seen), 0);
        chk("scan_completed", longint'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic reset_between();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
    endtask

    task automatic reset_mid_scan();
        int rel = -1;
        drive_coins();
        bus.player_x = 10'(bx[5]);
        bus.player_y = 10'(by[5]);
        enable = 1'b1;
        frame_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i == 2) frame_clk = 1'b0;
            if (bus.busy && rel < 0) rel = 0;
            else if (rel >= 0) rel++;
            if (rel == 3) Reset = 1'b1;
            if (rel == 4) begin
                chk("rst_coin_alive", longint'(bus.coin_alive), 255);
                chk("rst_coin_count", longint'(bus.coin_count), 0);
                chk("rst_busy",       longint'(bus.busy), 0);
                chk("rst_pulse",      longint'(bus.collect_pulse), 0);
                Reset = 1'b0;
            end
        end
        chk("rst_test_reached", longint'(rel >= 4), 1);
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        enable = 1'b0;
        bus.player_x = '0;
        bus.player_y = '0;
        base_layout();
        model_reset();
        drive_coins();
        repeat (3) @(negedge Clk);
        chk("reset_coin_alive",    longint'(bus.coin_alive), 255);
        chk("reset_coin_count",    longint'(bus.coin_count), 0);
        chk("reset_collect_pulse", longint'(bus.collect_pulse), 0);
        chk("reset_all_collected", longint'(bus.all_collected), 0);
        chk("reset_busy",          longint'(bus.busy), 0);
        Reset = 1'b0;
        @(negedge Clk);

        do_frame(50, 50, 1, 0, 0, -1);

        bx[3] = 400;
        by[6] = 700;
        do_frame(400, 300, 1, 0, 0, 3);
        do_frame(400, 300, 1, 0, 0, -1);

        do_frame(bx[0] + CW, by[0], 1, 0, 0, -1);
        do_frame(bx[0], by[0] + CH, 1, 0, 0, -1);
        do_frame(bx[0] - PW, by[0] - PH, 1, 0, 0, -1);

        bx[7] = 110;
        by[7] = 310;
        do_frame(100, 300, 1, 0, 0, -1);

        base_layout();
        for (int k = 0; k < N; k++)
            if (m_alive[k]) do_frame(bx[k], by[k], 1, 1, 0, -1);
        chk("all_collected_final", longint'(bus.all_collected), 1);
        chk("count_final",         longint'(bus.coin_count), N);

        reset_between();
        reset_mid_scan();

        do_frame(bx[2], by[2], 0, 0, 0, -1);
        do_frame(bx[4], by[4], 1, 0, 1, -1);

        for (int f = 0; f < 60; f++) begin
            int k;
            if ($urandom_range(0, 9) == 0) reset_between();
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < N; j++) begin
                    bx[j] = $urandom_range(0, 1000);
                    by[j] = $urandom_range(0, 990);
                end
            end
            k = $urandom_range(0, N - 1);
            do_frame(bx[k] + $urandom_range(0, 40) - 20,
                     by[k] + $urandom_range(0, 64) - 32,
                     $urandom_range(0, 5) != 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, -1);
        end

        chk("pulse_total", longint'(pulses_seen), longint'(exp_pulses));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
